// File: rtl/cvl_pkg.sv
// cvl_pkg: CCI-P header field positions, widths and helpers used by the read tag tracker.
//   C0 request header (74b): vc_sel[73:72] sop[71] rsvd[70] cl_len[69:68] req_type[67:64]
//                            rsvd[63:58] address[57:16] mdata[15:0]
//   C0 response header (28b): vc_used[27:26] rsvd[25] hit_miss[24] rsvd[23:22]
//                             cl_num[21:20] resp_type[19:16] mdata[15:0]
package cvl_pkg;

    localparam int DATA_WIDTH   = 512;
    localparam int MAX_QPI_RDS  = 128;
    localparam int RD_TAG_WIDTH = 7;

    localparam int CCIP_TXHDR_WIDTH     = 74;
    localparam int CCIP_TXHDR_MDATA_LSB = 0;
    localparam int CCIP_TXHDR_MDATA_MSB = 15;
    localparam int CCIP_TXHDR_ADDR_LSB  = 16;
    localparam int CCIP_TXHDR_ADDR_MSB  = 57;
    localparam int CCIP_TXHDR_REQ_LSB   = 64;
    localparam int CCIP_TXHDR_REQ_MSB   = 67;
    localparam int CCIP_TXHDR_LEN_LSB   = 68;
    localparam int CCIP_TXHDR_LEN_MSB   = 69;
    localparam int CCIP_TXHDR_SOP_BIT   = 71;
    localparam int CCIP_TXHDR_VC_LSB    = 72;
    localparam int CCIP_TXHDR_VC_MSB    = 73;

    localparam int CCIP_RXHDR_WIDTH     = 28;
    localparam int CCIP_RXHDR_MDATA_LSB = 0;
    localparam int CCIP_RXHDR_MDATA_MSB = 15;

    localparam logic [3:0] RdLine_I = 4'h6;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_IDLE
    } trk_state_t;

    // Single-cacheline read on VA (vc_sel=0, cl_len=0), tag carried in the low mdata bits.
    function automatic logic [CCIP_TXHDR_WIDTH-1:0] ccip_rd_hdr(
        input logic [41:0]             addr,
        input logic [RD_TAG_WIDTH-1:0] tag,
        input logic [3:0]              req
    );
        logic [CCIP_TXHDR_WIDTH-1:0] h;
        h = '0;
        h[CCIP_TXHDR_MDATA_MSB:CCIP_TXHDR_MDATA_LSB] = {{(16-RD_TAG_WIDTH){1'b0}}, tag};
        h[CCIP_TXHDR_ADDR_MSB:CCIP_TXHDR_ADDR_LSB]   = addr;
        h[CCIP_TXHDR_REQ_MSB:CCIP_TXHDR_REQ_LSB]     = req;
        h[CCIP_TXHDR_LEN_MSB:CCIP_TXHDR_LEN_LSB]     = 2'b00;
        h[CCIP_TXHDR_SOP_BIT]                        = 1'b1;
        h[CCIP_TXHDR_VC_MSB:CCIP_TXHDR_VC_LSB]       = 2'b00;
        return h;
    endfunction

endpackage

// File: rtl/ccip_tag_freelist.sv
// ccip_tag_freelist: tag bitmap, lowest-free priority encoder and in-flight counter.
//   clk, rst      : clock, synchronous active-high reset (frees every tag)
//   alloc         : take alloc_tag this cycle (only when avail)
//   free_en       : release free_tag this cycle (ignored if that tag is not allocated)
//   free_tag      : tag to release
//   avail         : at least one tag in 0..N-1 is free
//   alloc_tag     : lowest free tag
//   free_hit      : free_tag is currently allocated
//   count         : number of allocated tags
module ccip_tag_freelist
    import cvl_pkg::*;
#(
    parameter int N = MAX_QPI_RDS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alloc,
    input  logic                    free_en,
    input  logic [RD_TAG_WIDTH-1:0] free_tag,
    output logic                    avail,
    output logic [RD_TAG_WIDTH-1:0] alloc_tag,
    output logic                    free_hit,
    output logic [7:0]              count
);

    logic [N-1:0]           busy;
    logic [N-1:0]           set_mask;
    logic [N-1:0]           clr_mask;
    logic [MAX_QPI_RDS-1:0] busy_ext;
    logic                   do_free;

    // Widened view so any 7-bit tag can be looked up; tags >= N read as free.
    assign busy_ext = MAX_QPI_RDS'(busy);
    assign free_hit = busy_ext[free_tag];
    assign do_free  = free_en && free_hit;
    assign set_mask = alloc ? N'(1) << alloc_tag : '0;
    assign clr_mask = do_free ? N'(1) << free_tag : '0;

    // Downward scan so the last hit is the lowest free index. The tag freed this
    // cycle is still marked busy here, so it cannot be reissued until next cycle.
    always_comb begin
        avail     = 1'b0;
        alloc_tag = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                avail     = 1'b1;
                alloc_tag = RD_TAG_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= '0;
            count <= '0;
        end else begin
            busy  <= (busy | set_mask) & ~clr_mask;
            count <= count + {7'd0, alloc} - {7'd0, do_free};
        end
    end

endmodule

// File: rtl/ccip_rd_tag_tracker.sv
// ccip_rd_tag_tracker: issues CCI-P C0 cacheline reads with unique mdata tags and
// returns completions to the AFU tagged, with flush/drain support.
//   clk, rst                  : clock, synchronous active-high reset
//   req_valid/req_addr/req_ready : AFU read request (42-bit cacheline address)
//   tx_c0_hdr/tx_c0_rdvalid   : registered C0 request header and valid
//   rx_c0_almfull             : C0 TX almost-full back-pressure
//   rx_c0_hdr/data/rdvalid    : C0 read response
//   rsp_valid/rsp_tag/rsp_data: completion to AFU, one cycle after the response
//   flush/flushed             : stop issuing, drain, flushed high while idle
//   outstanding               : number of reads in flight
//   tag_err                   : (RD_TAG_CHECK_EN only) sticky, response with unallocated tag
// Build option RD_TAG_CHECK_EN: drop responses whose tag is not allocated and flag tag_err.
module ccip_rd_tag_tracker
    import cvl_pkg::*;
#(
    parameter int         MAX_OUTSTANDING = MAX_QPI_RDS,
    parameter logic [3:0] RD_REQ_TYPE     = RdLine_I
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    input  logic [41:0]                 req_addr,
    output logic                        req_ready,
    output logic [CCIP_TXHDR_WIDTH-1:0] tx_c0_hdr,
    output logic                        tx_c0_rdvalid,
    input  logic                        rx_c0_almfull,
    input  logic [CCIP_RXHDR_WIDTH-1:0] rx_c0_hdr,
    input  logic [DATA_WIDTH-1:0]       rx_c0_data,
    input  logic                        rx_c0_rdvalid,
    output logic                        rsp_valid,
    output logic [RD_TAG_WIDTH-1:0]     rsp_tag,
    output logic [DATA_WIDTH-1:0]       rsp_data,
    input  logic                        flush,
    output logic                        flushed,
`ifdef RD_TAG_CHECK_EN
    output logic                        tag_err,
`endif
    output logic [7:0]                  outstanding
);

    if (MAX_OUTSTANDING < 2 || MAX_OUTSTANDING > MAX_QPI_RDS ||
        (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_bad_param
        $error("MAX_OUTSTANDING must be a power of two in 2..128");
    end

    trk_state_t              state;
    trk_state_t              state_nxt;
    logic                    avail;
    logic                    accept;
    logic                    rx_known;
    logic                    fwd;
    logic [RD_TAG_WIDTH-1:0] alloc_tag;
    logic [RD_TAG_WIDTH-1:0] rx_tag;
    logic                    unused_rx_hdr;

    assign rx_tag        = rx_c0_hdr[CCIP_RXHDR_MDATA_LSB +: RD_TAG_WIDTH];
    assign unused_rx_hdr = ^rx_c0_hdr[CCIP_RXHDR_WIDTH-1:RD_TAG_WIDTH];
    assign req_ready     = !rst && !rx_c0_almfull && avail && state == ST_RUN;
    assign accept        = req_valid && req_ready;

`ifdef RD_TAG_CHECK_EN
    assign fwd = rx_c0_rdvalid && rx_known;
`else
    assign fwd = rx_c0_rdvalid;
`endif

    ccip_tag_freelist #(
        .N(MAX_OUTSTANDING)
    ) u_freelist (
        .clk      (clk),
        .rst      (rst),
        .alloc    (accept),
        .free_en  (rx_c0_rdvalid),
        .free_tag (rx_tag),
        .avail    (avail),
        .alloc_tag(alloc_tag),
        .free_hit (rx_known),
        .count    (outstanding)
    );

    always_comb begin
        state_nxt = (state == ST_RUN   && flush)              ? ST_DRAIN :
                    (state == ST_DRAIN && outstanding == '0) ? ST_IDLE  :
                    (state == ST_IDLE  && !flush)             ? ST_RUN   : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_RUN;
            flushed       <= 1'b0;
            tx_c0_rdvalid <= 1'b0;
            tx_c0_hdr     <= '0;
            rsp_valid     <= 1'b0;
            rsp_tag       <= '0;
            rsp_data      <= '0;
`ifdef RD_TAG_CHECK_EN
            tag_err       <= 1'b0;
`endif
        end else begin
            state         <= state_nxt;
            flushed       <= state_nxt == ST_IDLE;
            tx_c0_rdvalid <= accept;
            tx_c0_hdr     <= accept ? ccip_rd_hdr(req_addr, alloc_tag, RD_REQ_TYPE) : '0;
            rsp_valid     <= fwd;
            if (fwd) begin
                rsp_tag  <= rx_tag;
                rsp_data <= rx_c0_data;
            end
`ifdef RD_TAG_CHECK_EN
            tag_err       <= tag_err | (rx_c0_rdvalid && !rx_known);
`endif
        end
    end

endmodule

// File: tb/tb_ccip_rd_tag_tracker.sv
// tb_ccip_rd_tag_tracker: directed and randomized checks of the read tag tracker against a set-based model.
module tb_ccip_rd_tag_tracker;
    import cvl_pkg::*;

    localparam int MAXO  = 128;
    localparam int RUN   = 0;
    localparam int DRAIN = 1;
    localparam int IDLE  = 2;
`ifdef RD_TAG_CHECK_EN
    localparam bit CHK = 1'b1;
    logic tag_err;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic [41:0]  req_addr = '0;
    logic         req_ready;
    logic [73:0]  tx_c0_hdr;
    logic         tx_c0_rdvalid;
    logic         rx_c0_almfull = 1'b0;
    logic [27:0]  rx_c0_hdr = '0;
    logic [511:0] rx_c0_data = '0;
    logic         rx_c0_rdvalid = 1'b0;
    logic         rsp_valid;
    logic [6:0]   rsp_tag;
    logic [511:0] rsp_data;
    logic         flush = 1'b0;
    logic         flushed;
    logic [7:0]   outstanding;

    ccip_rd_tag_tracker dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_ready    (req_ready),
        .tx_c0_hdr    (tx_c0_hdr),
        .tx_c0_rdvalid(tx_c0_rdvalid),
        .rx_c0_almfull(rx_c0_almfull),
        .rx_c0_hdr    (rx_c0_hdr),
        .rx_c0_data   (rx_c0_data),
        .rx_c0_rdvalid(rx_c0_rdvalid),
        .rsp_valid    (rsp_valid),
        .rsp_tag      (rsp_tag),
        .rsp_data     (rsp_data),
        .flush        (flush),
        .flushed      (flushed),
`ifdef RD_TAG_CHECK_EN
        .tag_err      (tag_err),
`endif
        .outstanding  (outstanding)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    bit           mbusy [MAXO];
    int           mcount;
    int           mstate;
    bit           exp_err;
    bit           exp_ready, exp_accept, exp_rsp, exp_flushed, obs_ready;
    int           exp_tag;
    logic [41:0]  exp_addr;
    logic [6:0]   exp_rsp_tag;
    logic [511:0] exp_rsp_data;

    function automatic int lowest_free();
        for (int i = 0; i < MAXO; i++) if (!mbusy[i]) return i;
        return -1;
    endfunction

    function automatic logic [73:0] exp_hdr(input int tag, input logic [41:0] a);
        logic [73:0] h;
        h = '0;
        h[15:0]  = 16'(tag);
        h[57:16] = a;
        h[67:64] = 4'h6;
        h[71]    = 1'b1;
        return h;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic model_clear();
        foreach (mbusy[i]) mbusy[i] = 1'b0;
        mcount = 0;
        mstate = RUN;
        exp_err = 1'b0;
        exp_flushed = 1'b0;
        exp_rsp_data = '0;
    endtask

    // Drive one cycle of inputs (starting just after a rising edge), sample req_ready,
    // advance the model and the clock, and return just after the next rising edge.
    task automatic step(input bit rv, input logic [41:0] a, input bit af,
                        input bit rsv, input logic [6:0] rt, input bit fl);
        logic [511:0] d;
        bit known;
        d = rand512();
        req_valid = rv; req_addr = a; rx_c0_almfull = af;
        rx_c0_rdvalid = rsv; rx_c0_hdr = {21'd0, rt}; rx_c0_data = d; flush = fl;
        #1;
        obs_ready  = req_ready;
        exp_ready  = !af && mcount < MAXO && mstate == RUN;
        exp_accept = rv && exp_ready;
        exp_tag    = lowest_free();
        exp_addr   = a;
        known      = mbusy[rt];
        exp_rsp    = rsv && (known || !CHK);
        if (rsv && !known && CHK) exp_err = 1'b1;
        if (exp_rsp) begin
            exp_rsp_tag  = rt;
            exp_rsp_data = d;
        end
        mstate = (mstate == RUN && fl)       ? DRAIN :
                 (mstate == DRAIN && mcount == 0) ? IDLE :
                 (mstate == IDLE && !fl)     ? RUN : mstate;
        if (exp_accept) mbusy[exp_tag] = 1'b1;
        if (rsv && known) mbusy[rt] = 1'b0;
        mcount = 0;
        foreach (mbusy[i]) mcount += int'(mbusy[i]);
        exp_flushed = mstate == IDLE;
        @(posedge clk);
        #1;
    endtask

    task automatic drain_all();
        for (int i = 0; i < MAXO; i++) if (mbusy[i]) step(0, '0, 0, 1, 7'(i), 0);
        step(0, '0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b1; rx_c0_almfull = 1'b0; rx_c0_rdvalid = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
        n_checks++; if (tx_c0_rdvalid !== 1'b0) begin n_err++; $display("FAIL reset_rdvalid got %b exp 0", tx_c0_rdvalid); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        n_checks++; if (flushed !== 1'b0) begin n_err++; $display("FAIL reset_flushed got %b exp 0", flushed); end
        n_checks++; if (outstanding !== 8'd0) begin n_err++; $display("FAIL reset_outstanding got %0d exp 0", outstanding); end
        n_checks++; if (tx_c0_hdr !== 74'd0) begin n_err++; $display("FAIL reset_hdr got %h exp 0", tx_c0_hdr); end
        n_checks++; if (rsp_data !== 512'd0) begin n_err++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
`ifdef RD_TAG_CHECK_EN
        n_checks++; if (tag_err !== 1'b0) begin n_err++; $display("FAIL reset_tag_err got %b exp 0", tag_err); end
`endif
        rst = 1'b0;
        req_valid = 1'b0;
        model_clear();
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready got %b exp 1", req_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        step(1, 42'h123, 0, 0, 0, 0);
        n_checks++; if (obs_ready !== 1'b1) begin n_err++; $display("FAIL single_ready got %b exp 1", obs_ready); end
        n_checks++; if (tx_c0_rdvalid !== 1'b1) begin n_err++; $display("FAIL single_rdvalid got %b exp 1", tx_c0_rdvalid); end
        n_checks++; if (tx_c0_hdr !== exp_hdr(0, 42'h123)) begin n_err++; $display("FAIL single_hdr got %h exp %h", tx_c0_hdr, exp_hdr(0, 42'h123)); end
        n_checks++; if (outstanding !== 8'd1) begin n_err++; $display("FAIL single_outstanding got %0d exp 1", outstanding); end
        step(0, '0, 0, 0, 0, 0);
        n_checks++; if (tx_c0_rdvalid !== 1'b0) begin n_err++; $display("FAIL single_rdvalid_once got %b exp 0", tx_c0_rdvalid); end
        step(0, '0, 0, 1, 0, 0);
        n_checks++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_rsp_valid got %b exp 1", rsp_valid); end
        n_checks++; if (rsp_tag !== 7'd0) begin n_err++; $display("FAIL single_rsp_tag got %0d exp 0", rsp_tag); end
        n_checks++; if (rsp_data !== exp_rsp_data) begin n_err++; $display("FAIL single_rsp_data got %h exp %h", rsp_data, exp_rsp_data); end
        step(0, '0, 0, 0, 0, 0);
        n_checks++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_rsp_once got %b exp 0", rsp_valid); end
        n_checks++; if (outstanding !== 8'd0) begin n_err++; $display("FAIL single_freed got %0d exp 0", outstanding); end
    endtask

    task automatic test_fill();
        logic [41:0] a;
        for (int i = 0; i < MAXO; i++) begin
            a = 42'($urandom());
            step(1, a, 0, 0, 0, 0);
            n_checks++;
            if (tx_c0_rdvalid !== 1'b1 || tx_c0_hdr !== exp_hdr(i, a)) begin
                n_err++; $display("FAIL fill_tag_%0d got v=%b hdr=%h exp hdr=%h", i, tx_c0_rdvalid, tx_c0_hdr, exp_hdr(i, a));
            end
        end
        n_checks++; if (outstanding !== 8'd128) begin n_err++; $display("FAIL fill_outstanding got %0d exp 128", outstanding); end
        n_checks++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready got %b exp 0", req_ready); end
        step(1, 42'h55, 0, 1, 5, 0);
        n_checks++; if (obs_ready !== 1'b0 || tx_c0_rdvalid !== 1'b0) begin n_err++; $display("FAIL fill_full_issue got ready=%b v=%b exp 0/0", obs_ready, tx_c0_rdvalid); end
        n_checks++; if (outstanding !== 8'd127) begin n_err++; $display("FAIL fill_after_free got %0d exp 127", outstanding); end
        step(1, 42'h66, 0, 0, 0, 0);
        n_checks++; if (obs_ready !== 1'b1) begin n_err++; $display("FAIL fill_reready got %b exp 1", obs_ready); end
        n_checks++; if (tx_c0_hdr !== exp_hdr(5, 42'h66)) begin n_err++; $display("FAIL fill_reissue5 got %h exp %h", tx_c0_hdr, exp_hdr(5, 42'h66)); end
        drain_all();
        n_checks++; if (outstanding !== 8'd0) begin n_err++; $display("FAIL fill_drained got %0d exp 0", outstanding); end
    endtask

    task automatic test_almfull();
        step(1, 42'h3ff, 1, 0, 0, 0);
        n_checks++; if (obs_ready !== 1'b0 || tx_c0_rdvalid !== 1'b0) begin n_err++; $display("FAIL almfull_block got ready=%b v=%b exp 0/0", obs_ready, tx_c0_rdvalid); end
        step(1, 42'h3ff, 0, 0, 0, 0);
        n_checks++; if (tx_c0_rdvalid !== 1'b1 || tx_c0_hdr !== exp_hdr(0, 42'h3ff)) begin n_err++; $display("FAIL almfull_release got v=%b hdr=%h exp 1 %h", tx_c0_rdvalid, tx_c0_hdr, exp_hdr(0, 42'h3ff)); end
        drain_all();
    endtask

    task automatic test_same_cycle();
        for (int i = 0; i < 4; i++) step(1, 42'(i), 0, 0, 0, 0);
        step(1, 42'h77, 0, 1, 3, 0);
        n_checks++; if (tx_c0_hdr !== exp_hdr(4, 42'h77)) begin n_err++; $display("FAIL same_cycle_tag got %h exp %h", tx_c0_hdr, exp_hdr(4, 42'h77)); end
        n_checks++; if (outstanding !== 8'd4) begin n_err++; $display("FAIL same_cycle_count got %0d exp 4", outstanding); end
        n_checks++; if (rsp_valid !== 1'b1 || rsp_tag !== 7'd3) begin n_err++; $display("FAIL same_cycle_rsp got v=%b tag=%0d exp 1/3", rsp_valid, rsp_tag); end
        step(1, 42'h78, 0, 0, 0, 0);
        n_checks++; if (tx_c0_hdr !== exp_hdr(3, 42'h78)) begin n_err++; $display("FAIL same_cycle_reuse got %h exp %h", tx_c0_hdr, exp_hdr(3, 42'h78)); end
        drain_all();
    endtask

    task automatic test_flush();
        int k;
        for (int i = 0; i < 3; i++) step(1, 42'(i + 16), 0, 0, 0, 0);
        step(0, '0, 0, 0, 0, 1);
        step(1, 42'h9, 0, 0, 0, 1);
        n_checks++; if (obs_ready !== 1'b0 || tx_c0_rdvalid !== 1'b0) begin n_err++; $display("FAIL flush_block got ready=%b v=%b exp 0/0", obs_ready, tx_c0_rdvalid); end
        for (int i = 0; i < 3; i++) begin
            step(1, 42'h9, 0, 1, 7'(i), 1);
            n_checks++; if (rsp_valid !== 1'b1 || rsp_tag !== 7'(i) || obs_ready !== 1'b0) begin n_err++; $display("FAIL flush_rsp_%0d got v=%b tag=%0d ready=%b exp 1/%0d/0", i, rsp_valid, rsp_tag, obs_ready, i); end
        end
        k = 0;
        while (flushed !== 1'b1 && k < 8) begin step(0, '0, 0, 0, 0, 1); k++; end
        n_checks++; if (flushed !== 1'b1) begin n_err++; $display("FAIL flush_done got %b exp 1 (timeout)", flushed); end
        n_checks++; if (flushed !== exp_flushed) begin n_err++; $display("FAIL flush_model got %b exp %b", flushed, exp_flushed); end
        step(1, 42'h9, 0, 0, 0, 0);
        n_checks++; if (flushed !== 1'b0 || tx_c0_rdvalid !== 1'b0) begin n_err++; $display("FAIL flush_exit got flushed=%b v=%b exp 0/0", flushed, tx_c0_rdvalid); end
        step(1, 42'ha, 0, 0, 0, 0);
        n_checks++; if (obs_ready !== 1'b1 || tx_c0_hdr !== exp_hdr(0, 42'ha)) begin n_err++; $display("FAIL flush_run got ready=%b hdr=%h exp 1 %h", obs_ready, tx_c0_hdr, exp_hdr(0, 42'ha)); end
        drain_all();
    endtask

    task automatic test_unknown_tag();
        step(0, '0, 0, 1, 9, 0);
`ifdef RD_TAG_CHECK_EN
        n_checks++; if (tag_err !== 1'b1 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL unknown_tag got err=%b v=%b exp 1/0", tag_err, rsp_valid); end
`else
        n_checks++; if (rsp_valid !== 1'b1 || rsp_tag !== 7'd9) begin n_err++; $display("FAIL unknown_tag got v=%b tag=%0d exp 1/9", rsp_valid, rsp_tag); end
`endif
        n_checks++; if (outstanding !== 8'd0) begin n_err++; $display("FAIL unknown_tag_count got %0d exp 0", outstanding); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1, 42'(i + 40), 0, 0, 0, 0);
        test_reset();
        step(1, 42'h11, 0, 1, 1, 0);
`ifdef RD_TAG_CHECK_EN
        n_checks++; if (tag_err !== 1'b1 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL stale_tag got err=%b v=%b exp 1/0", tag_err, rsp_valid); end
`else
        n_checks++; if (rsp_valid !== 1'b1 || rsp_tag !== 7'd1) begin n_err++; $display("FAIL stale_tag got v=%b tag=%0d exp 1/1", rsp_valid, rsp_tag); end
`endif
        n_checks++; if (tx_c0_hdr !== exp_hdr(0, 42'h11) || outstanding !== 8'd1) begin n_err++; $display("FAIL post_reset_issue got hdr=%h cnt=%0d exp %h/1", tx_c0_hdr, outstanding, exp_hdr(0, 42'h11)); end
        drain_all();
    endtask

    task automatic test_random();
        bit rv, af, rsv, fl;
        logic [6:0] rt;
        fl = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            rv  = $urandom_range(0, 3) != 0;
            af  = $urandom_range(0, 4) == 0;
            rt  = 7'($urandom_range(0, 127));
            rsv = 1'b0;
            if (mcount > 0 && $urandom_range(0, 2) == 0) begin
                while (!mbusy[rt]) rt = rt + 7'd1;
                rsv = 1'b1;
            end else if ($urandom_range(0, 60) == 0) rsv = 1'b1;
            if (!fl && $urandom_range(0, 80) == 0) fl = 1'b1;
            else if (fl && $urandom_range(0, 12) == 0) fl = 1'b0;
            step(rv, 42'({$urandom(), $urandom()}), af, rsv, rt, fl);
            n_checks++; if (obs_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready c=%0d got %b exp %b", c, obs_ready, exp_ready); end
            n_checks++; if (tx_c0_rdvalid !== exp_accept) begin n_err++; $display("FAIL rnd_rdvalid c=%0d got %b exp %b", c, tx_c0_rdvalid, exp_accept); end
            if (exp_accept) begin
                n_checks++; if (tx_c0_hdr !== exp_hdr(exp_tag, exp_addr)) begin n_err++; $display("FAIL rnd_hdr c=%0d got %h exp %h", c, tx_c0_hdr, exp_hdr(exp_tag, exp_addr)); end
            end
            n_checks++; if (rsp_valid !== exp_rsp) begin n_err++; $display("FAIL rnd_rsp_valid c=%0d got %b exp %b", c, rsp_valid, exp_rsp); end
            if (exp_rsp) begin
                n_checks++; if (rsp_tag !== exp_rsp_tag || rsp_data !== exp_rsp_data) begin n_err++; $display("FAIL rnd_rsp c=%0d got tag=%0d exp tag=%0d", c, rsp_tag, exp_rsp_tag); end
            end
            n_checks++; if (outstanding !== 8'(mcount)) begin n_err++; $display("FAIL rnd_outstanding c=%0d got %0d exp %0d", c, outstanding, mcount); end
            n_checks++; if (flushed !== exp_flushed) begin n_err++; $display("FAIL rnd_flushed c=%0d got %b exp %b", c, flushed, exp_flushed); end
`ifdef RD_TAG_CHECK_EN
            n_checks++; if (tag_err !== exp_err) begin n_err++; $display("FAIL rnd_tag_err c=%0d got %b exp %b", c, tag_err, exp_err); end
`endif
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single();
        test_fill();
        test_almfull();
        test_same_cycle();
        test_flush();
        test_unknown_tag();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
